// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, grant codes and defaults for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  localparam int DEF_TIMEOUT = 1024;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts stalled busy cycles and flags expiry at TIMEOUT-1; TIMEOUT=0 never expires
module mem_arb_watchdog import mem_arb_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int W = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign expire = (TIMEOUT != 0) && en && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master native memory bus arbiter with watchdog termination of hung accesses
module mem_bus_arbiter import mem_arb_pkg::*; #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        bus_err,
  output logic        err_master,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);
  localparam int WD = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic last_q, last_d, err_master_q, err_master_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0] err_count_q, err_count_d;
  logic busy0, busy1, act, mv, wd_en, expire;
  // Gating with reset forces every bus-facing output to 0 while reset is held.
  assign busy0 = !reset && (state_q == BUSY0);
  assign busy1 = !reset && (state_q == BUSY1);
  assign act = busy0 || busy1;
  assign mv = busy0 ? m0_valid : busy1 && m1_valid;
  assign wd_en = act && mv && !s_ready;
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT), .W(WD)) u_wd (
    .clk(clk), .reset(reset), .clr(!wd_en || expire), .en(wd_en), .expire(expire)
  );
  assign s_valid = act && mv && !expire;
  assign s_instr = busy0 ? m0_instr : busy1 && m1_instr;
  assign s_addr = busy0 ? m0_addr : busy1 ? m1_addr : '0;
  assign s_wdata = busy0 ? m0_wdata : busy1 ? m1_wdata : '0;
  assign s_wstrb = busy0 ? m0_wstrb : busy1 ? m1_wstrb : '0;
  assign m0_ready = busy0 && m0_valid && (s_ready || expire);
  assign m1_ready = busy1 && m1_valid && (s_ready || expire);
  assign m0_rdata = !busy0 ? '0 : expire ? ERR_RDATA : s_rdata;
  assign m1_rdata = !busy1 ? '0 : expire ? ERR_RDATA : s_rdata;
  assign grant = busy0 ? GNT_M0 : busy1 ? GNT_M1 : GNT_NONE;
  assign bus_err = expire;
  assign err_master = err_master_q;
  assign err_addr = err_addr_q;
  assign err_count = err_count_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    err_master_d = err_master_q;
    err_addr_d = err_addr_q;
    err_count_d = err_count_q;
    if (state_q == IDLE)
      state_d = (m0_valid && m1_valid) ? ((FIXED_PRIO || last_q) ? BUSY0 : BUSY1) :
                m0_valid ? BUSY0 : m1_valid ? BUSY1 : IDLE;
    else if (!mv || s_ready || expire) begin
      state_d = IDLE;
      last_d = mv ? busy1 : last_q;
    end
    if (expire) begin
      err_master_d = busy1;
      err_addr_d = busy1 ? m1_addr : m0_addr;
      err_count_d = (&err_count_q) ? err_count_q : err_count_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      err_master_q <= 1'b0;
      err_addr_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      err_master_q <= err_master_d;
      err_addr_q <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for a round-robin/TIMEOUT=8 and a fixed-priority/TIMEOUT=0 arbiter
module tb_mem_bus_arbiter;
  typedef struct {logic mst; logic [31:0] rdata; logic err;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int checks = 0, failures = 0;
  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  logic m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic auto_ack = 0, sr_man = 0;
  logic [31:0] sd_man = 0;
  logic a_m0_ready, a_m1_ready, a_s_valid, a_s_instr, a_s_ready, a_bus_err, a_err_master;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, a_s_rdata, a_err_addr;
  logic [3:0] a_s_wstrb;
  logic [1:0] a_grant;
  logic [7:0] a_err_count;
  logic b_m0_ready, b_m1_ready, b_s_valid, b_s_instr, b_s_ready, b_bus_err, b_err_master;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata, b_s_rdata, b_err_addr;
  logic [3:0] b_s_wstrb;
  logic [1:0] b_grant;
  logic [7:0] b_err_count;
  always #5 clk = ~clk;
  // Auto slave acks in the first busy cycle with data tagging the owner (A5A50001 / A5A50002).
  assign a_s_ready = auto_ack ? (a_grant != 2'b00) : sr_man;
  assign a_s_rdata = auto_ack ? {16'hA5A5, 14'h0, a_grant} : sd_man;
  assign b_s_ready = auto_ack ? (b_grant != 2'b00) : sr_man;
  assign b_s_rdata = auto_ack ? {16'hA5A5, 14'h0, b_grant} : sd_man;
  mem_bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(rst_a),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
    .s_valid(a_s_valid), .s_instr(a_s_instr), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
    .s_ready(a_s_ready), .s_rdata(a_s_rdata), .grant(a_grant), .bus_err(a_bus_err),
    .err_master(a_err_master), .err_addr(a_err_addr), .err_count(a_err_count)
  );
  mem_bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(rst_b),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .s_valid(b_s_valid), .s_instr(b_s_instr), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
    .s_ready(b_s_ready), .s_rdata(b_s_rdata), .grant(b_grant), .bus_err(b_bus_err),
    .err_master(b_err_master), .err_addr(b_err_addr), .err_count(b_err_count)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic sel(input bit b);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick;
    tick;
    if (b) rst_b = 1'b0;
    else rst_a = 1'b0;
  endtask
  task automatic timeout_m0;
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0400;
    qa.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
    repeat (9) tick;
    m0_valid = 1'b0;
  endtask
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_m0_ready || a_m1_ready || a_bus_err) begin
      if (qa.size() == 0) chk("a_unexpected", {29'h0, a_bus_err, a_m1_ready, a_m0_ready}, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_ready", {30'h0, a_m1_ready, a_m0_ready}, e.mst ? 32'd2 : 32'd1);
        chk("a_rdata", e.mst ? a_m1_rdata : a_m0_rdata, e.rdata);
        chk("a_bus_err", {31'h0, a_bus_err}, {31'h0, e.err});
      end
    end
  end
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_m0_ready || b_m1_ready || b_bus_err) begin
      if (qb.size() == 0) chk("b_unexpected", {29'h0, b_bus_err, b_m1_ready, b_m0_ready}, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_ready", {30'h0, b_m1_ready, b_m0_ready}, e.mst ? 32'd2 : 32'd1);
        chk("b_rdata", e.mst ? b_m1_rdata : b_m0_rdata, e.rdata);
        chk("b_bus_err", {31'h0, b_bus_err}, {31'h0, e.err});
      end
    end
  end
  initial begin
    m0_valid = 1'b1;
    @(negedge clk);
    chk("rst_s_valid", {31'h0, a_s_valid}, 32'd0);
    chk("rst_m0_ready", {31'h0, a_m0_ready}, 32'd0);
    m0_valid = 1'b0;
    sel(0);
    @(negedge clk);
    chk("rst_grant", {30'h0, a_grant}, 32'd0);
    chk("rst_err_count", {24'h0, a_err_count}, 32'd0);
    chk("rst_err_master", {31'h0, a_err_master}, 32'd0);
    chk("rst_err_addr", a_err_addr, 32'd0);
    // single master read with a slave ack two cycles after s_valid
    tick;
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0100;
    qa.push_back('{1'b0, 32'h1234_5678, 1'b0});
    @(negedge clk);
    chk("t1_svalid_idle", {31'h0, a_s_valid}, 32'd0);
    tick;
    @(negedge clk);
    chk("t1_svalid_busy", {31'h0, a_s_valid}, 32'd1);
    chk("t1_grant", {30'h0, a_grant}, 32'd1);
    chk("t1_s_addr", a_s_addr, 32'h0000_0100);
    tick;
    tick;
    sr_man = 1'b1;
    sd_man = 32'h1234_5678;
    tick;
    sr_man = 1'b0;
    m0_valid = 1'b0;
    @(negedge clk);
    chk("t1_grant_done", {30'h0, a_grant}, 32'd0);
    // round-robin contention from reset
    sel(0);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    m0_addr = 32'h0000_0700;
    m1_addr = 32'h0000_0704;
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) qa.push_back('{i[0], i[0] ? 32'hA5A5_0002 : 32'hA5A5_0001, 1'b0});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_rr_grant", {30'h0, a_grant}, i[0] ? (i[1] ? 32'd2 : 32'd1) : 32'd0);
      tick;
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    auto_ack = 1'b0;
    // m1 write times out after 8 busy cycles
    m1_valid = 1'b1;
    m1_addr = 32'h1000_0004;
    m1_wdata = 32'h55AA_55AA;
    m1_wstrb = 4'hF;
    qa.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
    tick;
    @(negedge clk);
    chk("t4_s_wstrb", {28'h0, a_s_wstrb}, 32'hF);
    chk("t4_s_addr", a_s_addr, 32'h1000_0004);
    repeat (7) tick;
    @(negedge clk);
    chk("t4_svalid_forced", {31'h0, a_s_valid}, 32'd0);
    tick;
    m1_valid = 1'b0;
    m1_wstrb = 4'h0;
    @(negedge clk);
    chk("t4_err_master", {31'h0, a_err_master}, 32'd1);
    chk("t4_err_addr", a_err_addr, 32'h1000_0004);
    chk("t4_err_count", {24'h0, a_err_count}, 32'd1);
    chk("t4_grant_idle", {30'h0, a_grant}, 32'd0);
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0200;
    auto_ack = 1'b1;
    qa.push_back('{1'b0, 32'hA5A5_0001, 1'b0});
    tick;
    tick;
    m0_valid = 1'b0;
    auto_ack = 1'b0;
    // s_ready in the expiry cycle wins over the watchdog
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0300;
    qa.push_back('{1'b0, 32'hCAFE_F00D, 1'b0});
    repeat (8) tick;
    sr_man = 1'b1;
    sd_man = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t5_svalid", {31'h0, a_s_valid}, 32'd1);
    tick;
    sr_man = 1'b0;
    m0_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_count", {24'h0, a_err_count}, 32'd1);
    // 256 timeouts saturate the error counter
    sel(0);
    repeat (256) timeout_m0;
    @(negedge clk);
    chk("t6_err_count_sat", {24'h0, a_err_count}, 32'd255);
    // reset during a transfer
    tick;
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0500;
    tick;
    rst_a = 1'b1;
    @(negedge clk);
    chk("t8_rst_svalid", {31'h0, a_s_valid}, 32'd0);
    tick;
    rst_a = 1'b0;
    m0_valid = 1'b0;
    @(negedge clk);
    chk("t8_grant", {30'h0, a_grant}, 32'd0);
    chk("t8_svalid", {31'h0, a_s_valid}, 32'd0);
    chk("t8_err_count", {24'h0, a_err_count}, 32'd0);
    chk("t8_err_addr", a_err_addr, 32'd0);
    // abandon leaves last_grant at m0, so m1 wins the next tie
    tick;
    m0_valid = 1'b1;
    auto_ack = 1'b1;
    qa.push_back('{1'b0, 32'hA5A5_0001, 1'b0});
    tick;
    tick;
    m0_valid = 1'b0;
    auto_ack = 1'b0;
    m1_valid = 1'b1;
    m1_addr = 32'h0000_0600;
    tick;
    @(negedge clk);
    chk("t9_grant_busy", {30'h0, a_grant}, 32'd2);
    tick;
    m1_valid = 1'b0;
    @(negedge clk);
    chk("t9_abandon_ready", {31'h0, a_m1_ready}, 32'd0);
    chk("t9_abandon_err", {31'h0, a_bus_err}, 32'd0);
    tick;
    @(negedge clk);
    chk("t9_grant_idle", {30'h0, a_grant}, 32'd0);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    auto_ack = 1'b1;
    qa.push_back('{1'b1, 32'hA5A5_0002, 1'b0});
    tick;
    @(negedge clk);
    chk("t9_last_grant", {30'h0, a_grant}, 32'd2);
    tick;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    auto_ack = 1'b0;
    // fixed priority: m0 keeps winning until it drops valid
    sel(1);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    auto_ack = 1'b1;
    repeat (4) qb.push_back('{1'b0, 32'hA5A5_0001, 1'b0});
    qb.push_back('{1'b1, 32'hA5A5_0002, 1'b0});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_fp_grant", {30'h0, b_grant}, i[0] ? 32'd1 : 32'd0);
      tick;
    end
    m0_valid = 1'b0;
    @(negedge clk);
    chk("t3_fp_idle", {30'h0, b_grant}, 32'd0);
    tick;
    @(negedge clk);
    chk("t3_fp_m1", {30'h0, b_grant}, 32'd2);
    tick;
    m1_valid = 1'b0;
    auto_ack = 1'b0;
    // TIMEOUT=0 never terminates a stalled slave
    sel(1);
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0800;
    repeat (5001) tick;
    @(negedge clk);
    chk("t7_still_busy", {30'h0, b_grant}, 32'd1);
    chk("t7_svalid", {31'h0, b_s_valid}, 32'd1);
    chk("t7_err_count", {24'h0, b_err_count}, 32'd0);
    tick;
    qb.push_back('{1'b0, 32'h600D_F00D, 1'b0});
    sr_man = 1'b1;
    sd_man = 32'h600D_F00D;
    tick;
    sr_man = 1'b0;
    m0_valid = 1'b0;
    tick;
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
